// File: rtl/param_tensor_core.sv
// Sequential NxN unsigned matrix-multiply engine: one output element per cycle
// through N parallel multipliers, with optional accumulate and saturation.
module param_tensor_core #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  start_in,
  input  logic                  accumulate_enable_in,
  input  logic                  saturate_enable_in,
  input  logic [DATA_WIDTH-1:0] tensor_core_input1 [N][N],
  input  logic [DATA_WIDTH-1:0] tensor_core_input2 [N][N],
  output logic [OUT_WIDTH-1:0]  tensor_core_output [N][N],
  output logic                  busy_out,
  output logic                  is_done_with_calculation
);

  localparam int IW    = $clog2(N);
  localparam int SUM_W = 2 * DATA_WIDTH + $clog2(N);
  localparam int ACC_W = ((SUM_W > OUT_WIDTH) ? SUM_W : OUT_WIDTH) + 1;

  typedef enum logic {IDLE, COMPUTE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          row_q, col_q;
  logic                   acc_mode_q, sat_mode_q;
  logic                   last_element;
  logic [SUM_W-1:0]       dot_sum;
  logic [ACC_W-1:0]       acc_val;
  logic [OUT_WIDTH-1:0]   result;

  assign last_element = (row_q == IW'(N - 1)) && (col_q == IW'(N - 1));

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = COMPUTE;
      COMPUTE: if (last_element) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dot product of row A[row] and column B[col], then optional accumulate and clamp.
  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < N; i++) begin
      dot_sum = dot_sum + SUM_W'(tensor_core_input1[row_q][i]) * SUM_W'(tensor_core_input2[i][col_q]);
    end
    acc_val = ACC_W'(dot_sum) + (acc_mode_q ? ACC_W'(tensor_core_output[row_q][col_q]) : '0);
    if (sat_mode_q && (|acc_val[ACC_W-1:OUT_WIDTH])) result = '1;
    else                                            result = acc_val[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      row_q                    <= '0;
      col_q                    <= '0;
      acc_mode_q               <= 1'b0;
      sat_mode_q               <= 1'b0;
      busy_out                 <= 1'b0;
      is_done_with_calculation <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          tensor_core_output[r][c] <= '0;
        end
      end
    end else begin
      busy_out                 <= (state_d == COMPUTE);
      is_done_with_calculation <= (state_q == COMPUTE) && last_element;
      if (state_q == IDLE) begin
        if (start_in) begin
          row_q      <= '0;
          col_q      <= '0;
          acc_mode_q <= accumulate_enable_in;
          sat_mode_q <= saturate_enable_in;
        end
      end else begin
        tensor_core_output[row_q][col_q] <= result;
        // Counters wrap back to zero after the final element.
        if (col_q == IW'(N - 1)) begin
          col_q <= '0;
          row_q <= last_element ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

endmodule
